// File: rtl/hazard_ctrl_if.sv
// ID-stage instruction info and pipeline-control outputs shared by the hazard unit.
// The slave modport is the hazard unit; the master modport is whoever drives ID.
interface hazard_ctrl_if #(
  parameter int RW   = 5,
  parameter int NSRC = 3
);
  logic                 start;
  logic                 id_valid;
  logic [NSRC*RW-1:0]   id_src;
  logic [NSRC-1:0]      id_src_used;
  logic [RW-1:0]        id_dst;
  logic                 id_wr;
  logic                 id_ld;
  logic                 id_hlt;
  logic                 ma_request;
  logic                 ma_answer;
  logic                 run_en;
  logic                 stall_id;
  logic                 nop_id;
  logic [NSRC*3-1:0]    fwd_sel;
  logic                 halted;
  logic                 ma_err;

  modport master (
    output start, id_valid, id_src, id_src_used, id_dst, id_wr, id_ld, id_hlt,
           ma_request, ma_answer,
    input  run_en, stall_id, nop_id, fwd_sel, halted, ma_err
  );

  modport slave (
    input  start, id_valid, id_src, id_src_used, id_dst, id_wr, id_ld, id_hlt,
           ma_request, ma_answer,
    output run_en, stall_id, nop_id, fwd_sel, halted, ma_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/pipeline-control unit: shadow scoreboard of in-flight writes, forwarding
// selects, load-use stall, PC-write flush sequencing, halt latch and memory-timeout watch.
module hazard_ctrl #(
  parameter int NREG       = 32,
  parameter int RW         = 5,
  parameter int NSRC       = 3,
  parameter int FWD_DEPTH  = 3,
  parameter int LD_LAT     = 1,
  parameter int FLUSH_CYC  = 3,
  parameter int MA_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  generate
    if (FWD_DEPTH < 1 || FWD_DEPTH > 7 || LD_LAT >= FWD_DEPTH || NREG > (1 << RW) ||
        MA_TIMEOUT < 1 || MA_TIMEOUT > 65535) begin : g_bad_params
      $error("hazard_ctrl: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_HALT} state_t;

  localparam logic [15:0] MA_TO   = 16'(MA_TIMEOUT);
  localparam logic [15:0] FL_INIT = 16'(FLUSH_CYC);

  state_t                         r_state;
  logic [15:0]                    r_fcnt;
  logic [15:0]                    r_ma_cnt;
  logic                           r_ma_err;
  logic [FWD_DEPTH-1:0]           r_v;
  logic [FWD_DEPTH-1:0]           r_wr;
  logic [FWD_DEPTH-1:0]           r_ld;
  logic [FWD_DEPTH-1:0][RW-1:0]   r_dst;

  logic                           w_run_en;
  logic                           w_stall;
  logic                           w_nop;
  logic                           w_adv;
  logic                           w_issue;
  logic [NSRC*3-1:0]              w_fwd;
  logic [2:0]                     w_sel;
  logic                           w_sel_stall;
  logic [RW-1:0]                  w_src;
  logic                           w_hit;

  assign w_run_en = (bus.ma_request == bus.ma_answer);
  assign w_nop    = bus.start | (r_state != S_RUN);
  assign w_adv    = w_run_en & ~w_stall & ~w_nop;
  assign w_issue  = w_adv & bus.id_valid;

  // Per-operand forwarding select: scan oldest to youngest so the youngest match wins.
  always_comb begin
    w_fwd       = '0;
    w_stall     = 1'b0;
    w_sel       = 3'd0;
    w_sel_stall = 1'b0;
    w_src       = '0;
    w_hit       = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      w_src       = bus.id_src[s*RW +: RW];
      w_sel       = 3'd0;
      w_sel_stall = 1'b0;
      for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
        w_hit       = bus.id_src_used[s] && (w_src != '0) && r_v[i] && r_wr[i] &&
                      (r_dst[i] == w_src);
        w_sel       = w_hit ? 3'(i + 1) : w_sel;
        w_sel_stall = w_hit ? (r_ld[i] && (i < LD_LAT)) : w_sel_stall;
      end
      w_fwd[s*3 +: 3] = w_sel;
      w_stall         = w_stall | w_sel_stall;
    end
  end

  assign bus.run_en   = w_run_en;
  assign bus.stall_id = w_stall;
  assign bus.nop_id   = w_nop;
  assign bus.fwd_sel  = w_fwd;
  assign bus.halted   = (r_state == S_HALT);
  assign bus.ma_err   = r_ma_err;

  // Shadow pipeline: shifts only on run_en, entry 0 takes the issued instruction or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v   <= '0;
      r_wr  <= '0;
      r_ld  <= '0;
      r_dst <= '0;
    end else if (bus.start) begin
      r_v   <= '0;
      r_wr  <= '0;
      r_ld  <= '0;
      r_dst <= '0;
    end else if (w_run_en) begin
      for (int i = FWD_DEPTH - 1; i >= 1; i--) begin
        r_v[i]   <= r_v[i-1];
        r_wr[i]  <= r_wr[i-1];
        r_ld[i]  <= r_ld[i-1];
        r_dst[i] <= r_dst[i-1];
      end
      r_v[0]   <= w_issue;
      r_wr[0]  <= bus.id_wr;
      r_ld[0]  <= bus.id_ld;
      r_dst[0] <= bus.id_dst;
    end else begin
      r_v <= r_v;
    end
  end

  // Control FSM; start overrides every state, HLT takes priority over a PC write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fcnt  <= 16'd0;
    end else if (bus.start) begin
      r_state <= S_RUN;
      r_fcnt  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_IDLE;
        S_RUN: begin
          if (w_issue && bus.id_hlt) begin
            r_state <= S_HALT;
          end else if (w_issue && bus.id_wr && (bus.id_dst == '0) && (FLUSH_CYC != 0)) begin
            r_state <= S_FLUSH;
            r_fcnt  <= FL_INIT;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_FLUSH: begin
          if (w_run_en && (r_fcnt <= 16'd1)) begin
            r_state <= S_RUN;
            r_fcnt  <= 16'd0;
          end else if (w_run_en) begin
            r_fcnt <= r_fcnt - 16'd1;
          end else begin
            r_fcnt <= r_fcnt;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory handshake watchdog; the counter saturates at the timeout and the error is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ma_cnt <= 16'd0;
      r_ma_err <= 1'b0;
    end else if (w_run_en) begin
      r_ma_cnt <= 16'd0;
    end else begin
      if (r_ma_cnt != MA_TO) begin
        r_ma_cnt <= r_ma_cnt + 16'd1;
      end else begin
        r_ma_cnt <= r_ma_cnt;
      end
      if (r_ma_cnt == (MA_TO - 16'd1)) begin
        r_ma_err <= 1'b1;
      end else begin
        r_ma_err <= r_ma_err;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;
  localparam int RW   = 5;
  localparam int NSRC = 3;

  typedef struct {
    string      name;
    logic [8:0] fwd;
    logic       stall;
    logic       nop;
    logic       halted;
    logic       run_en;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t m_e;

  hazard_ctrl_if #(.RW(RW), .NSRC(NSRC)) hif ();

  hazard_ctrl #(
    .NREG(32), .RW(RW), .NSRC(NSRC), .FWD_DEPTH(3), .LD_LAT(1),
    .FLUSH_CYC(3), .MA_TIMEOUT(255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic [8:0] fwd, input logic stall,
                          input logic nop, input logic halted, input logic run_en,
                          input logic err);
    exp_t e;
    e.name = name; e.fwd = fwd; e.stall = stall; e.nop = nop;
    e.halted = halted; e.run_en = run_en; e.err = err;
    q.push_back(e);
  endtask

  task automatic instr(input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                       input logic [2:0] used, input logic [RW-1:0] dst,
                       input logic wr, input logic ld, input logic hlt);
    hif.id_valid    = 1'b1;
    hif.id_src      = {5'd0, s1, s0};
    hif.id_src_used = used;
    hif.id_dst      = dst;
    hif.id_wr       = wr;
    hif.id_ld       = ld;
    hif.id_hlt      = hlt;
  endtask

  task automatic bubble();
    hif.id_valid    = 1'b0;
    hif.id_src      = '0;
    hif.id_src_used = 3'b000;
    hif.id_dst      = 5'd0;
    hif.id_wr       = 1'b0;
    hif.id_ld       = 1'b0;
    hif.id_hlt      = 1'b0;
  endtask

  // Monitor: compare each queued expectation in the middle of its cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      checks++;
      if (hif.fwd_sel !== m_e.fwd || hif.stall_id !== m_e.stall || hif.nop_id !== m_e.nop ||
          hif.halted !== m_e.halted || hif.run_en !== m_e.run_en || hif.ma_err !== m_e.err) begin
        errors++;
        $display("FAIL %s: got fwd=%0d stall=%b nop=%b halted=%b run_en=%b err=%b, want fwd=%0d stall=%b nop=%b halted=%b run_en=%b err=%b",
                 m_e.name, hif.fwd_sel, hif.stall_id, hif.nop_id, hif.halted, hif.run_en,
                 hif.ma_err, m_e.fwd, m_e.stall, m_e.nop, m_e.halted, m_e.run_en, m_e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1);
  end

  initial begin
    hif.start = 1'b0; hif.ma_request = 1'b0; hif.ma_answer = 1'b0;
    bubble();
    tick();
    push_exp("reset", 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0; hif.start = 1'b1;
    push_exp("start_idle", 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    hif.start = 1'b0;
    instr(5'd1, 5'd2, 3'b011, 5'd3, 1'b1, 1'b0, 1'b0);
    push_exp("add_r3", 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    instr(5'd3, 5'd1, 3'b011, 5'd4, 1'b1, 1'b0, 1'b0);
    push_exp("alu_fwd", 9'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    instr(5'd2, 5'd0, 3'b001, 5'd5, 1'b1, 1'b1, 1'b0);
    push_exp("ld_r5", 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    instr(5'd5, 5'd5, 3'b011, 5'd6, 1'b1, 1'b0, 1'b0);
    push_exp("ld_use_stall", 9'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    push_exp("ld_use_fwd2", 9'd18, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    instr(5'd1, 5'd0, 3'b001, 5'd7, 1'b1, 1'b0, 1'b0);
    push_exp("add_r7a", 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    instr(5'd7, 5'd0, 3'b001, 5'd7, 1'b1, 1'b0, 1'b0);
    push_exp("add_r7b", 9'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    instr(5'd7, 5'd0, 3'b011, 5'd8, 1'b1, 1'b0, 1'b0);
    push_exp("youngest_wins", 9'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    instr(5'd1, 5'd0, 3'b001, 5'd0, 1'b1, 1'b1, 1'b0);
    push_exp("ld_pc", 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    instr(5'd0, 5'd8, 3'b011, 5'd9, 1'b1, 1'b0, 1'b0);
    push_exp("flush1_r0", 9'd16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    push_exp("flush2", 9'd24, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    push_exp("flush3", 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    push_exp("flush_done", 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    instr(5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1);
    push_exp("hlt", 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++) begin
      tick();
      bubble();
      push_exp("halted_hold", 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    tick();
    hif.start = 1'b1;
    push_exp("start_from_halt", 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    hif.start = 1'b0;
    instr(5'd1, 5'd0, 3'b001, 5'd11, 1'b1, 1'b0, 1'b0);
    push_exp("run_after_halt", 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    hif.start = 1'b1;
    instr(5'd11, 5'd0, 3'b001, 5'd12, 1'b1, 1'b0, 1'b1);
    push_exp("start_with_hlt", 9'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    hif.start = 1'b0;
    instr(5'd11, 5'd0, 3'b001, 5'd12, 1'b1, 1'b0, 1'b0);
    push_exp("shadow_cleared", 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    instr(5'd1, 5'd0, 3'b001, 5'd13, 1'b1, 1'b0, 1'b0);
    push_exp("add_r13", 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    hif.ma_request = 1'b1;
    instr(5'd13, 5'd0, 3'b001, 5'd14, 1'b1, 1'b0, 1'b0);
    push_exp("ma_wait_k0", 9'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 260; k++) begin
      tick();
      push_exp((k == 254) ? "ma_no_err_yet" : (k == 255) ? "ma_err_set" : "ma_frozen",
               9'd1, 1'b0, 1'b0, 1'b0, 1'b0, (k >= 255) ? 1'b1 : 1'b0);
    end
    tick();
    hif.ma_answer = 1'b1;
    push_exp("ma_answer", 9'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    push_exp("ma_resume_shift", 9'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    hif.start = 1'b1;
    bubble();
    push_exp("err_survives_start", 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    hif.start = 1'b0;
    rst = 1'b1;
    push_exp("async_rst", 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    instr(5'd1, 5'd0, 3'b001, 5'd2, 1'b1, 1'b0, 1'b0);
    push_exp("idle_after_rst", 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    bubble();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and pipeline-control unit for the vasm pipelined core. It sits beside the ID stage and tracks in-flight register writes in an internal shadow pipeline of `FWD_DEPTH` stages. From that it produces per-operand forwarding selects, load-use stalls, flush sequencing after PC writes, halt latching and memory-handshake clock gating. It supersedes fixed three-stage hazard decoding with a scoreboard that scales in operand count, forwarding depth and load latency, and adds a memory-timeout monitor.

## Interface
Parameters:
- `NREG`, 32: architectural registers. Register 0 is PC.
- `RW`, 5: register index width (clog2 `NREG`).
- `NSRC`, 3: source operands per instruction (X, Y, MD).
- `FWD_DEPTH`, 3: forwardable stages after ID (EX, MEM, WB). Range 1..7.
- `LD_LAT`, 1: load data first forwardable from shadow index `LD_LAT`. Must be < `FWD_DEPTH`.
- `FLUSH_CYC`, 3: bubbles inserted after a PC write.
- `MA_TIMEOUT`, 255: mismatch cycles before `ma_err`. Range 1..65535.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: master-unit start pulse.
- `id_valid` in 1: ID holds a real instruction.
- `id_src` in NSRC*RW: source register indices; operand s at [s*RW +: RW].
- `id_src_used` in NSRC: operand s is read.
- `id_dst` in RW: destination register.
- `id_wr` in 1: instruction writes `id_dst`.
- `id_ld` in 1: instruction is LD.
- `id_hlt` in 1: instruction is HLT.
- `ma_request` in 1: memory request toggle.
- `ma_answer` in 1: memory answer toggle.
- `run_en` out 1: global pipeline clock enable.
- `stall_id` out 1: hold IF/ID and inject a bubble into EX.
- `nop_id` out 1: replace the ID instruction with NOP.
- `fwd_sel` out NSRC*3: per operand, 0 = register file, k = shadow index k-1.
- `halted` out 1: FSM is in HALT.
- `ma_err` out 1: sticky memory-timeout flag.

## Operation
- **Advance** = `run_en` & ~`stall_id` & ~`nop_id`.
- **Shadow pipeline.** Entries 0..FWD_DEPTH-1 each hold {v, wr, ld, dst}. Every cycle with `run_en`=1 the entries shift 0→1→…; the last entry drops off.
  - Entry 0 takes the ID info when Advance is true, otherwise a bubble (v=0).
  - When `run_en`=0 the shadow is frozen.
- **Match.** Operand s matches entry i when `id_src_used[s]`, src≠0, v, wr and dst==src.
- **Forwarding.** The youngest (lowest i) matching entry wins and drives `fwd_sel[s]` = i+1. No match gives 0.
- **Load-use stall.** `stall_id`=1 if any operand's winning entry has ld=1 and i < `LD_LAT`. While stalled, `fwd_sel` is still driven; ID re-evaluates next cycle.
- **FSM states:** IDLE, RUN, FLUSH, HALT. Reset state is IDLE.
  - IDLE: `nop_id`=1.
  - `start` in any state: shadow cleared, flush counter cleared, next state RUN. `nop_id`=1 in the `start` cycle.
  - RUN, Advance with `id_hlt`: go to HALT.
  - RUN, Advance with `id_wr` & `id_dst`==0 (PC write, incl. LD to PC): go to FLUSH, counter = `FLUSH_CYC`.
  - FLUSH: `nop_id`=1. Counter decrements on `run_en` cycles. Reaching 0 returns to RUN. `FLUSH_CYC`=0 means an immediate return to RUN.
  - HALT: `nop_id`=1, `halted`=1. Left only by `start` or `rst`.
- **Memory gating.** `run_en` = (`ma_request` == `ma_answer`), combinational.
  - A 16-bit counter increments while they differ and clears when they are equal.
  - When the counter reaches `MA_TIMEOUT`, `ma_err` is set. It stays set until `rst` (`start` does not clear it). The counter saturates.

## Timing
- Reset values: state IDLE, shadow all v=0, counters 0, `ma_err` 0. Outputs: `stall_id` 0, `nop_id` 1, `fwd_sel` all 0, `halted` 0, `run_en` follows its inputs.
- `fwd_sel`, `stall_id` and `run_en` are combinational from registered state and same-cycle ID inputs. `nop_id` and `halted` are decoded from registered state, except `nop_id` also asserts combinationally in the `start` cycle.
- A dependent instruction directly after an ALU op sees `fwd_sel`=1 with zero stall.
- A dependent instruction directly after LD with `LD_LAT`=1 stalls exactly 1 cycle, then sees `fwd_sel`=2.
- A PC write at cycle t gives `nop_id`=1 for cycles t+1..t+FLUSH_CYC, assuming `run_en` stays high.
- `rst` mid-operation takes effect immediately. `start` together with `id_hlt` resolves as `start`.

## Test plan
- After reset, `start` pulse, then ADD r3; ADD r4←r3 → cycle 2: `fwd_sel[0]`=1, `stall_id`=0.
- LD r5; SUB r6←r5,r5 → 1 stall cycle, then `fwd_sel[0]`=`fwd_sel[1]`=2.
- ADD r7 at t, ADD r7 at t+1, read r7 at t+2 → `fwd_sel`=1 (youngest wins, not 2). A read of r0 always gives 0.
- LD r0 (PC) issued at t → `nop_id`=1 for t+1..t+3, RUN from t+4.
- HLT → `halted`=1 and `nop_id` held for 100 cycles. `start` → `halted`=0, shadow empty.
- Toggle `ma_request` with no answer → `run_en`=0 and shadow frozen. `ma_err`=1 after 255 cycles. Answer → `run_en`=1 and `ma_err` stays 1 until `rst`.
